// File: rtl/packet_admission_fifo_if.sv
// AXI4-Stream bundle used on both sides of the packet admission FIFO.
// The master side drives data and valid; the slave side drives ready.
interface packet_admission_fifo_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/packet_admission_fifo.sv
// Word FIFO behind the packet cutter: each packet is admitted or dropped whole at its
// first beat, depending on free space, so the cutter is never stalled mid-packet.
module packet_admission_fifo #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH_BITS      = 6,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                          axi_aclk,
    input  logic                          axi_resetn,
    packet_admission_fifo_if.slave        s_axis,
    packet_admission_fifo_if.master       m_axis,
    input  logic                          drop_en,
    input  logic                          stats_clear,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_admit_cnt,
    output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_drop_cnt
);

    localparam int DEPTH    = 2 ** FIFO_DEPTH_BITS;
    localparam int OCC_W    = FIFO_DEPTH_BITS + 1;
    localparam int S_STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int M_STRB_W = C_M_AXIS_DATA_WIDTH / 8;
    localparam int BPW_LOG2 = $clog2(S_STRB_W);
    localparam int ENT_W    = 1 + C_S_AXIS_TUSER_WIDTH + S_STRB_W + C_S_AXIS_DATA_WIDTH;

    typedef enum logic [1:0] {ST_SOP, ST_ACCEPT, ST_DROP} state_e;

    state_e                     state_q, state_d;
    logic [ENT_W-1:0]           mem_q [DEPTH];
    logic [ENT_W-1:0]           rd_ent;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]           occ_q, free;
    logic [C_S_AXI_DATA_WIDTH-1:0] admit_q, drop_q;
    logic [16:0]                len_rnd;
    logic [11:0]                need_raw, need;
    logic                       fits, full, empty, beat, pop, push, admit_inc, drop_inc;

    assign len_rnd  = {1'b0, s_axis.tuser[15:0]} + 17'(S_STRB_W - 1);
    assign need_raw = 12'(len_rnd >> BPW_LOG2);
    assign need     = (need_raw == 12'd0) ? 12'd1 : need_raw;
    // Space freed by a pop in this cycle is deliberately not counted.
    assign free     = OCC_W'(DEPTH) - occ_q;
    assign fits     = need <= 12'(free);

    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);

    // Beats that will be discarded need no space, so with admission control on the
    // input only stalls while an admitted packet overruns its declared length.
    assign s_axis.tready = !full || (state_q == ST_DROP) || (state_q == ST_SOP && drop_en);
    assign beat          = s_axis.tvalid && s_axis.tready;

    assign rd_ent        = mem_q[rd_ptr_q];
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = rd_ent[C_M_AXIS_DATA_WIDTH-1:0];
    assign m_axis.tstrb  = rd_ent[C_S_AXIS_DATA_WIDTH +: M_STRB_W];
    assign m_axis.tuser  = rd_ent[C_S_AXIS_DATA_WIDTH + S_STRB_W +: C_M_AXIS_TUSER_WIDTH];
    assign m_axis.tlast  = rd_ent[ENT_W-1];
    assign pop           = m_axis.tvalid && m_axis.tready;

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        admit_inc = 1'b0;
        drop_inc  = 1'b0;
        if (beat) begin
            case (state_q)
                ST_SOP: begin
                    if (!drop_en || fits) begin
                        push      = 1'b1;
                        admit_inc = 1'b1;
                        if (!s_axis.tlast) state_d = ST_ACCEPT;
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_axis.tlast) state_d = ST_DROP;
                    end
                end
                ST_ACCEPT: begin
                    push = 1'b1;
                    if (s_axis.tlast) state_d = ST_SOP;
                end
                ST_DROP: begin
                    if (s_axis.tlast) state_d = ST_SOP;
                end
                default: state_d = ST_SOP;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q  <= ST_SOP;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (push) mem_q[wr_ptr_q] <= {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            admit_q <= '0;
            drop_q  <= '0;
        end else if (stats_clear) begin
            admit_q <= '0;
            drop_q  <= '0;
        end else begin
            if (admit_inc) admit_q <= admit_q + 1'b1;
            if (drop_inc)  drop_q  <= drop_q + 1'b1;
        end
    end

    assign pkt_admit_cnt = admit_q;
    assign pkt_drop_cnt  = drop_q;

endmodule

// File: tb/tb_packet_admission_fifo.sv
// Directed bench for packet_admission_fifo: admission, drop, backpressure, reset, stats clear.
module tb_packet_admission_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drop_en, stats_clear;
    logic [31:0] admit_cnt, drop_cnt;
    int          passed = 0, failed = 0, total = 0, seq = 0;

    typedef struct packed {
        logic         last;
        logic [15:0]  len;
        logic [31:0]  strb;
        logic [255:0] data;
    } exp_t;
    exp_t q[$];

    packet_admission_fifo_if #(.DATA_W(256), .USER_W(128)) s_if ();
    packet_admission_fifo_if #(.DATA_W(256), .USER_W(128)) m_if ();

    packet_admission_fifo dut (
        .axi_aclk(clk), .axi_resetn(rst_n), .s_axis(s_if), .m_axis(m_if),
        .drop_en(drop_en), .stats_clear(stats_clear),
        .pkt_admit_cnt(admit_cnt), .pkt_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkword(input int n);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) w[32*j +: 32] = {n[15:0], 8'(j), 8'hC3};
        return w;
    endfunction

    function automatic logic [31:0] mkstrb(input int n);
        return {n[7:0], ~n[7:0], n[15:8], 8'h5A};
    endfunction

    // Called on a falling edge; returns on the falling edge after the last beat.
    task automatic send_pkt(input int nw, input logic [15:0] len, input bit admit, input bit term);
        for (int i = 0; i < nw; i++) begin
            int tries = 0;
            bit done = 0, ok = 0;
            s_if.tvalid = 1'b1;
            s_if.tdata  = mkword(seq);
            s_if.tstrb  = mkstrb(seq);
            s_if.tuser  = {112'(seq), len};
            s_if.tlast  = term && (i == nw - 1);
            while (!done) begin
                #1;
                if (s_if.tready) begin
                    @(posedge clk);
                    done = 1; ok = 1;
                end else begin
                    tries++;
                    if (tries > 200) begin
                        check("send_timeout", 0, 1);
                        done = 1;
                    end
                    @(negedge clk);
                end
            end
            if (ok && admit) q.push_back('{s_if.tlast, len, mkstrb(seq), mkword(seq)});
            seq++;
            if (ok) @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Check the head word against the scoreboard, then pop it in one cycle.
    task automatic pop_expect();
        exp_t e;
        if (q.size() == 0) begin
            check("q_empty", 1, 0);
            return;
        end
        e = q.pop_front();
        check("out_valid", m_if.tvalid, 1'b1);
        check("out_data", m_if.tdata, e.data);
        check("out_strb", m_if.tstrb, e.strb);
        check("out_last", m_if.tlast, e.last);
        check("out_len", m_if.tuser[15:0], e.len);
        m_if.tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_if.tready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; drop_en = 1'b1; stats_clear = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", m_if.tvalid, 1'b0);
        check("rst_admit", admit_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", s_if.tready, 1'b1);

        // T1: 60-byte packet, two words, first word visible one cycle after its push
        send_pkt(1, 16'd60, 1, 0);
        check("t1_latency_valid", m_if.tvalid, 1'b1);
        check("t1_latency_data", m_if.tdata, q[0].data);
        send_pkt(1, 16'd60, 1, 1);
        check("t1_admit", admit_cnt, 1);
        check("t1_drop", drop_cnt, 0);
        pop_expect();
        pop_expect();
        check("t1_empty", m_if.tvalid, 1'b0);

        // T2: four 16-word packets fill depth 64; the fifth is dropped whole
        for (int p = 0; p < 4; p++) send_pkt(16, 16'd512, 1, 1);
        check("t2_ready_full", s_if.tready, 1'b1);
        send_pkt(16, 16'd512, 0, 1);
        check("t2_admit", admit_cnt, 5);
        check("t2_drop", drop_cnt, 1);
        for (int k = 0; k < 64; k++) pop_expect();
        check("t2_drained", m_if.tvalid, 1'b0);

        // T3: at occupancy 63 a 1-word packet fits, a 2-word packet does not
        send_pkt(63, 16'd2016, 1, 1);
        check("t3_ready_63", s_if.tready, 1'b1);
        send_pkt(1, 16'd20, 1, 1);
        check("t3_ready_64", s_if.tready, 1'b1);
        check("t3_admit", admit_cnt, 7);
        send_pkt(2, 16'd40, 0, 1);
        check("t3_ready_after", s_if.tready, 1'b1);
        check("t3_drop", drop_cnt, 2);
        for (int k = 0; k < 64; k++) pop_expect();
        check("t3_drained", m_if.tvalid, 1'b0);

        // T4: admission off, full FIFO backpressures instead of dropping
        drop_en = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(16, 16'd512, 1, 1);
        check("t4_ready_full", s_if.tready, 1'b0);
        fork
            send_pkt(2, 16'd64, 1, 1);
            begin
                repeat (3) @(negedge clk);
                check("t4_stalled", s_if.tready, 1'b0);
                pop_expect();
                repeat (2) @(negedge clk);
                pop_expect();
            end
        join
        check("t4_drop", drop_cnt, 2);
        check("t4_admit", admit_cnt, 12);
        for (int k = 0; k < 64; k++) pop_expect();
        check("t4_drained", m_if.tvalid, 1'b0);
        drop_en = 1'b1;

        // T5: reset with 10 words of an open packet buffered
        send_pkt(10, 16'd512, 1, 0);
        check("t5_valid_before", m_if.tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_valid_rst", m_if.tvalid, 1'b0);
        check("t5_admit_rst", admit_cnt, 0);
        check("t5_drop_rst", drop_cnt, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pkt(1, 16'd8, 1, 1);
        check("t5_admit_after", admit_cnt, 1);
        pop_expect();
        check("t5_empty", m_if.tvalid, 1'b0);

        // T6: oversize packet dropped; then stats_clear on the same edge as a drop
        send_pkt(1, 16'd4000, 0, 1);
        check("t6_drop", drop_cnt, 1);
        check("t6_admit", admit_cnt, 1);
        stats_clear = 1'b1;
        send_pkt(1, 16'd4000, 0, 1);
        stats_clear = 1'b0;
        check("t6_drop_clr", drop_cnt, 0);
        check("t6_admit_clr", admit_cnt, 0);
        check("t6_nothing_pushed", m_if.tvalid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
